// File: rtl/buffer_access_arbiter.sv
// Buffer access arbiter: grants one burst at a time, round-robin, to two
// requesters sharing the write/read data buffer (two DEPTH-deep sync FIFOs).
// Credit counters mirror both FIFO levels so a burst is only admitted when
// the write FIFO has room for it or the read FIFO already holds it.
module buffer_access_arbiter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         req_write,
    input  logic [2*LEN_W-1:0] req_len,
    output logic [1:0]         gnt,
    output logic               beat,
    output logic               done,
    output logic               buf_ready,
    output logic               buf_mem_write,
    output logic               buf_mem_read,
    input  logic               wfifo_pop,
    input  logic               rfifo_push,
    output logic [LEN_W-1:0]   wr_level,
    output logic [LEN_W-1:0]   rd_level,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W:0]   DEPTH_X = (LEN_W+1)'(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state;
    state_t           state_next;

    // Latched burst context
    logic             idx;
    logic             dir;
    logic [LEN_W-1:0] cnt;
    // Requester served most recently; the other one has priority
    logic             last;

    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       len_ok;
    logic [1:0]       elig;
    logic             win;
    logic             win_dir;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W:0]   wr_space;

    // Next values of the registered outputs
    logic [1:0]       gnt_d;
    logic             beat_d;
    logic             done_d;
    logic             mem_write_d;
    logic             mem_read_d;
    logic             busy_d;
    logic             sel_idx;
    logic             sel_dir;
    logic [LEN_W-1:0] wr_level_d;
    logic [LEN_W-1:0] rd_level_d;
    logic             err_d;
    logic             wr_beat;
    logic             rd_beat;

    assign len0 = req_len[LEN_W-1:0];
    assign len1 = req_len[2*LEN_W-1:LEN_W];

    // Admission check: one burst is eligible only if the FIFO it touches can absorb or supply it
    function automatic logic can_admit(
        input logic             r,
        input logic             w,
        input logic             ok,
        input logic [LEN_W-1:0] l,
        input logic [LEN_W:0]   space,
        input logic [LEN_W-1:0] rl
    );
        logic fits;
        if (w) begin
            fits = (space >= {1'b0, l});
        end else begin
            fits = ({1'b0, rl} >= {1'b0, l});
        end
        return r && ok && fits;
    endfunction

    // Eligibility of each requester and the round-robin winner
    always_comb begin
        wr_space  = DEPTH_X - {1'b0, wr_level};
        len_ok[0] = (len0 != '0) && ({1'b0, len0} <= DEPTH_X);
        len_ok[1] = (len1 != '0) && ({1'b0, len1} <= DEPTH_X);
        elig[0]   = can_admit(req[0], req_write[0], len_ok[0], len0, wr_space, rd_level);
        elig[1]   = can_admit(req[1], req_write[1], len_ok[1], len1, wr_space, rd_level);
        // Requester 1 wins when it is alone, or when both are eligible and 0 was served last
        win       = elig[1] & (~elig[0] | ~last);
        win_dir   = req_write[win];
        win_len   = win ? len1 : len0;
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: admit, run exactly len beats, one done cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (cnt == ONE_L) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output can be registered
    always_comb begin
        sel_idx     = (state == IDLE) ? win : idx;
        sel_dir     = (state == IDLE) ? win_dir : dir;
        gnt_d       = '0;
        beat_d      = 1'b0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        if (state_next == XFER) begin
            gnt_d[sel_idx] = 1'b1;
            beat_d         = 1'b1;
            mem_write_d    = sel_dir;
            mem_read_d     = ~sel_dir;
        end
        done_d = (state_next == DONE);
        busy_d = (state_next != IDLE);
    end

    // Burst context: latch winner on admission, count beats, remember who was served
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idx  <= 1'b0;
            dir  <= 1'b0;
            cnt  <= '0;
            last <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        idx <= win;
                        dir <= win_dir;
                        cnt <= win_len;
                    end
                end
                XFER: begin
                    cnt <= cnt - ONE_L;
                end
                DONE: begin
                    last <= idx;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Credit counters and sticky error, driven by this cycle's beat and the memory-side pulses
    always_comb begin
        wr_beat    = beat & buf_mem_write;
        rd_beat    = beat & buf_mem_read;
        wr_level_d = wr_level;
        rd_level_d = rd_level;
        err_d      = err;
        if (wr_beat && !wfifo_pop) begin
            wr_level_d = wr_level + ONE_L;
        end else if (!wr_beat && wfifo_pop) begin
            if (wr_level == '0) begin
                err_d = 1'b1;
            end else begin
                wr_level_d = wr_level - ONE_L;
            end
        end
        if (rfifo_push && !rd_beat) begin
            if (rd_level == DEPTH_L) begin
                err_d = 1'b1;
            end else begin
                rd_level_d = rd_level + ONE_L;
            end
        end else if (rd_beat && !rfifo_push) begin
            rd_level_d = rd_level - ONE_L;
        end
        // Request lengths are only looked at while idle
        if ((state == IDLE) && (|(req & ~len_ok))) begin
            err_d = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            gnt           <= '0;
            beat          <= 1'b0;
            done          <= 1'b0;
            buf_ready     <= 1'b0;
            buf_mem_write <= 1'b0;
            buf_mem_read  <= 1'b0;
            busy          <= 1'b0;
            wr_level      <= '0;
            rd_level      <= '0;
            err           <= 1'b0;
        end else begin
            gnt           <= gnt_d;
            beat          <= beat_d;
            done          <= done_d;
            buf_ready     <= beat_d;
            buf_mem_write <= mem_write_d;
            buf_mem_read  <= mem_read_d;
            busy          <= busy_d;
            wr_level      <= wr_level_d;
            rd_level      <= rd_level_d;
            err           <= err_d;
        end
    end

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Testbench for buffer_access_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// timestamp-based behavioural model.
module tb_buffer_access_arbiter;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   req_write;
    logic [7:0]   req_len;
    logic [1:0]   gnt;
    logic         beat;
    logic         done;
    logic         buf_ready;
    logic         buf_mem_write;
    logic         buf_mem_read;
    logic         wfifo_pop;
    logic         rfifo_push;
    logic [3:0]   wr_level;
    logic [3:0]   rd_level;
    logic         busy;
    logic         err;

    always #5 sys_clk = ~sys_clk;

    buffer_access_arbiter #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .req           (req),
        .req_write     (req_write),
        .req_len       (req_len),
        .gnt           (gnt),
        .beat          (beat),
        .done          (done),
        .buf_ready     (buf_ready),
        .buf_mem_write (buf_mem_write),
        .buf_mem_read  (buf_mem_read),
        .wfifo_pop     (wfifo_pop),
        .rfifo_push    (rfifo_push),
        .wr_level      (wr_level),
        .rd_level      (rd_level),
        .busy          (busy),
        .err           (err)
    );

    int checks = 0;
    int errors = 0;

    // Model: a burst is described by the cycles of its first/last beat
    int cyc     = 0;
    bit started = 1'b0;
    int m_wr    = 0;
    int m_rd    = 0;
    bit m_err   = 1'b0;
    bit m_last  = 1'b1;
    bit b_valid = 1'b0;
    bit b_idx   = 1'b0;
    bit b_dir   = 1'b0;
    int b_start = 0;
    int b_end   = 0;
    int free_at = 0;

    // Advance the model by one cycle using the inputs of the cycle now ending
    always @(posedge sys_clk) begin : model_step
        int c;
        int wr;
        int rd;
        int ln [2];
        bit el [2];
        bit ok;
        bit e;
        bit bt;
        bit wb;
        bit rb;
        bit w;
        c = cyc;
        if (rst) begin
            m_wr    <= 0;
            m_rd    <= 0;
            m_err   <= 1'b0;
            m_last  <= 1'b1;
            b_valid <= 1'b0;
            free_at <= c + 1;
            started <= 1'b1;
        end else begin
            wr = m_wr;
            rd = m_rd;
            e  = m_err;
            bt = b_valid && (c >= b_start) && (c <= b_end);
            if (c >= free_at) begin
                ln[0] = int'(req_len[3:0]);
                ln[1] = int'(req_len[7:4]);
                for (int i = 0; i < 2; i++) begin
                    ok = (ln[i] >= 1) && (ln[i] <= DEPTH);
                    if (req[i] && !ok) e = 1'b1;
                    el[i] = req[i] && ok &&
                            (req_write[i] ? ((DEPTH - wr) >= ln[i]) : (rd >= ln[i]));
                end
                if (el[0] || el[1]) begin
                    w = (el[0] && el[1]) ? !m_last : el[1];
                    b_valid <= 1'b1;
                    b_idx   <= w;
                    b_dir   <= req_write[w];
                    b_start <= c + 1;
                    b_end   <= c + ln[w];
                    free_at <= c + ln[w] + 2;
                    m_last  <= w;
                end
            end
            wb = bt && b_dir;
            rb = bt && !b_dir;
            if (wb && !wfifo_pop) wr = wr + 1;
            else if (wfifo_pop && !wb) begin
                if (wr == 0) e = 1'b1;
                else wr = wr - 1;
            end
            if (rfifo_push && !rb) begin
                if (rd == DEPTH) e = 1'b1;
                else rd = rd + 1;
            end else if (rb && !rfifo_push) rd = rd - 1;
            m_wr  <= wr;
            m_rd  <= rd;
            m_err <= e;
        end
        cyc <= cyc + 1;
    end

    // Compare every DUT output against the model once per cycle
    always @(negedge sys_clk) begin : compare
        logic [16:0] exp_v;
        logic [16:0] act_v;
        bit bt;
        bit dn;
        bit bs;
        if (started) begin
            bt = b_valid && (cyc >= b_start) && (cyc <= b_end);
            dn = b_valid && (cyc == b_end + 1);
            bs = b_valid && (cyc >= b_start) && (cyc <= b_end + 1);
            exp_v = {bt && b_idx, bt && !b_idx, bt, dn, bt, bt && b_dir, bt && !b_dir,
                     4'(m_wr), 4'(m_rd), bs, m_err};
            act_v = {gnt, beat, done, buf_ready, buf_mem_write, buf_mem_read,
                     wr_level, rd_level, busy, err};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_compare cyc=%0d got=%b want=%b (gnt,beat,done,rdy,mw,mr,wr,rd,busy,err)",
                         cyc, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst        = 1'b1;
        req        = 2'b00;
        wfifo_pop  = 1'b0;
        rfifo_push = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (busy !== 1'b0 && n < 40);
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout got busy=%b want=0", busy);
        end
    endtask

    function automatic logic [3:0] pick_len();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(1, 8));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req        = 2'b00;
        req_write  = 2'b00;
        req_len    = 8'h00;
        wfifo_pop  = 1'b0;
        rfifo_push = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        chk("reset_outputs", 32'({gnt, beat, done, buf_ready, buf_mem_write, buf_mem_read,
                                  wr_level, rd_level, busy, err}), 0);

        // Single write of 3 beats from requester 0
        req = 2'b01; req_write = 2'b01; req_len = 8'h03;
        for (int j = 1; j <= 3; j++) begin
            @(negedge sys_clk);
            chk("t1_gnt", 32'(gnt), 1);
            chk("t1_mem_write", 32'(buf_mem_write), 1);
            if (j == 1) req = 2'b00;
        end
        @(negedge sys_clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_gnt_off", 32'(gnt), 0);
        chk("t1_wr_level", 32'(wr_level), 3);
        @(negedge sys_clk);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_done_once", 32'(done), 0);

        // Round-robin between two write requesters of length 2
        do_reset();
        req = 2'b11; req_write = 2'b11; req_len = 8'h22;
        for (int k = 0; k < 4; k++) begin
            for (int j = 1; j <= 4; j++) begin
                @(negedge sys_clk);
                chk("t2_rr_gnt", 32'(gnt), (j <= 2) ? ((k % 2 == 0) ? 1 : 2) : 0);
                wfifo_pop = (wr_level != 4'd0);
            end
        end
        req = 2'b00; wfifo_pop = 1'b0;
        wait_idle();

        // Write admission blocked until a pop frees room
        do_reset();
        req = 2'b01; req_write = 2'b01; req_len = 8'h06;
        @(negedge sys_clk);
        req = 2'b00;
        wait_idle();
        chk("t3_wr_level6", 32'(wr_level), 6);
        req = 2'b01; req_len = 8'h03;
        repeat (3) begin
            @(negedge sys_clk);
            chk("t3_blocked", 32'(gnt), 0);
        end
        wfifo_pop = 1'b1;
        @(negedge sys_clk);
        wfifo_pop = 1'b0;
        chk("t3_wr_level5", 32'(wr_level), 5);
        chk("t3_still_blocked", 32'(gnt), 0);
        @(negedge sys_clk);
        chk("t3_granted", 32'(gnt), 1);
        req = 2'b00;
        wait_idle();
        chk("t3_wr_level8", 32'(wr_level), 8);

        // Read admission waits for two pushes
        req = 2'b10; req_write = 2'b00; req_len = 8'h20;
        repeat (2) begin
            @(negedge sys_clk);
            chk("t4_blocked", 32'(gnt), 0);
        end
        rfifo_push = 1'b1;
        @(negedge sys_clk);
        chk("t4_one_push", 32'(gnt), 0);
        @(negedge sys_clk);
        rfifo_push = 1'b0;
        chk("t4_rd_level2", 32'(rd_level), 2);
        chk("t4_not_yet", 32'(gnt), 0);
        for (int j = 0; j < 2; j++) begin
            @(negedge sys_clk);
            chk("t4_gnt", 32'(gnt), 2);
            chk("t4_mem_read", 32'(buf_mem_read), 1);
            req = 2'b00;
        end
        wait_idle();
        chk("t4_rd_level0", 32'(rd_level), 0);

        // Counter corner cases
        do_reset();
        req = 2'b01; req_write = 2'b01; req_len = 8'h02;
        @(negedge sys_clk);
        req = 2'b00; wfifo_pop = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        wfifo_pop = 1'b0;
        chk("t5_beat_pop_level", 32'(wr_level), 0);
        chk("t5_beat_pop_err", 32'(err), 0);
        wfifo_pop = 1'b1;
        @(negedge sys_clk);
        wfifo_pop = 1'b0;
        chk("t5_underflow_level", 32'(wr_level), 0);
        chk("t5_underflow_err", 32'(err), 1);
        do_reset();
        rfifo_push = 1'b1;
        repeat (8) @(negedge sys_clk);
        chk("t5_rd_full", 32'(rd_level), 8);
        chk("t5_rd_full_err", 32'(err), 0);
        @(negedge sys_clk);
        rfifo_push = 1'b0;
        chk("t5_overflow_level", 32'(rd_level), 8);
        chk("t5_overflow_err", 32'(err), 1);

        // Illegal lengths are never granted; the other requester still is
        do_reset();
        req = 2'b11; req_write = 2'b11; req_len = 8'h90;
        repeat (4) begin
            @(negedge sys_clk);
            chk("t6_illegal_gnt", 32'(gnt), 0);
        end
        chk("t6_illegal_err", 32'(err), 1);
        req_len = 8'h20;
        @(negedge sys_clk);
        chk("t6_other_served", 32'(gnt), 2);
        req = 2'b00;
        wait_idle();

        // Reset on the 2nd beat of a 4-beat burst
        do_reset();
        req = 2'b01; req_write = 2'b01; req_len = 8'h04;
        @(negedge sys_clk);
        req = 2'b00;
        @(negedge sys_clk);
        chk("t6_second_beat", 32'(beat), 1);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        chk("t6_abort_outputs", 32'({gnt, beat, done, buf_ready, buf_mem_write, buf_mem_read,
                                     wr_level, rd_level, busy, err}), 0);
        @(negedge sys_clk);
        chk("t6_no_done", 32'(done), 0);
        chk("t6_idle", 32'(busy), 0);

        // Randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            @(negedge sys_clk);
            rst        = ($urandom_range(0, 199) == 0);
            req        = 2'($urandom);
            req_write  = 2'($urandom);
            req_len    = {pick_len(), pick_len()};
            wfifo_pop  = ($urandom_range(0, 2) == 0);
            rfifo_push = ($urandom_range(0, 2) == 0);
        end
        @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
